cu_multicycle: RTL

- Parametrised multicycle control unit, successor to the fixed 4-register, 20-bit-instruction CU.
- Accepts instructions over a valid/ready handshake and decodes std_op, loadR, storeR and NOP.
- Drives ALU and data-memory controls, and owns a NUM_REGS-entry register file.
- Adds proper store sequencing (w_r asserted), memory wait-states via mem_ready, a memory timeout fault, a retire pulse, and an optional hardwired-zero R0.

---
 rtl/cu_pkg.sv | 44 ++++
 rtl/cu_regfile.sv | 40 ++++
 rtl/cu_multicycle.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types and instruction-field layout for the multicycle control unit.
// Field positions are functions of register-index and data widths so every user agrees on them.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_MEM_ACCESS = 3'd4,
        ST_WRITE_BACK = 3'd5,
        ST_FAULT      = 3'd6
    } state_t;

    localparam logic [1:0] TYPE_NOP   = 2'b00;
    localparam logic [1:0] TYPE_STD   = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;
    localparam logic [1:0] TYPE_STORE = 2'b11;

    localparam logic [3:0] OPCODE_IDLE = 4'b1111;
    localparam int         OPCODE_W    = 4;

    // Instruction layout, MSB first: {type, rd, rs1, rs2, offset, opcode}
    function automatic int offset_lsb();
        return OPCODE_W;
    endfunction

    function automatic int rs2_lsb(input int data_width);
        return OPCODE_W + data_width;
    endfunction

    function automatic int rs1_lsb(input int ra_bits, input int data_width);
        return OPCODE_W + data_width + ra_bits;
    endfunction

    function automatic int rd_lsb(input int ra_bits, input int data_width);
        return OPCODE_W + data_width + 2 * ra_bits;
    endfunction

    function automatic int type_lsb(input int ra_bits, input int data_width);
        return OPCODE_W + data_width + 3 * ra_bits;
    endfunction

endpackage

// File: rtl/cu_regfile.sv
// NUM_REGS x DATA_WIDTH register file: two asynchronous read ports, one synchronous write port.
// Resets each entry to its own index; optionally hardwires entry 0 to zero.
module cu_regfile
    import cu_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REGS   = 4,
    parameter  int R0_ZERO    = 0,
    localparam int RA_BITS    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RA_BITS-1:0]    raddr1,
    input  logic [RA_BITS-1:0]    raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  wr_en,
    input  logic [RA_BITS-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_blocked;

    assign wr_blocked = (R0_ZERO != 0) && (waddr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else if (wr_en && !wr_blocked) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = ((R0_ZERO != 0) && (raddr1 == '0)) ? '0 : regs[raddr1];
    assign rdata2 = ((R0_ZERO != 0) && (raddr2 == '0)) ? '0 : regs[raddr2];

endmodule

// File: rtl/cu_multicycle.sv
// Parametrised multicycle control unit: accepts instructions over valid/ready, sequences
// std_op/loadR/storeR through the datapath, waits on memory, and faults on a memory timeout.
module cu_multicycle
    import cu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_REGS    = 4,
    parameter  int MEM_TIMEOUT = 15,
    parameter  int R0_ZERO     = 0,
    localparam int RA_BITS     = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = 2 + 3 * RA_BITS + DATA_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [DATA_WIDTH-1:0]  result2,
    input  logic                   mem_ready,
    output logic [DATA_WIDTH-1:0]  operand1,
    output logic [DATA_WIDTH-1:0]  operand2,
    output logic [DATA_WIDTH-1:0]  offset,
    output logic [3:0]             opcode,
    output logic                   sel1,
    output logic                   sel3,
    output logic                   w_r,
    output logic                   retire,
    output logic                   fault
);

    localparam int OFF_LSB  = offset_lsb();
    localparam int RS2_LSB  = rs2_lsb(DATA_WIDTH);
    localparam int RS1_LSB  = rs1_lsb(RA_BITS, DATA_WIDTH);
    localparam int RD_LSB   = rd_lsb(RA_BITS, DATA_WIDTH);
    localparam int TYPE_LSB = type_lsb(RA_BITS, DATA_WIDTH);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t                  state;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic [INSTR_WIDTH-1:0]  cur;
    logic [1:0]              cur_type;
    logic [RA_BITS-1:0]      cur_rd;
    logic [RA_BITS-1:0]      cur_rs1;
    logic [RA_BITS-1:0]      cur_rs2;
    logic [DATA_WIDTH-1:0]   cur_offset;
    logic [3:0]              cur_opcode;
    logic [RA_BITS-1:0]      raddr2;
    logic [DATA_WIDTH-1:0]   rdata1;
    logic [DATA_WIDTH-1:0]   rdata2;
    logic                    wr_en;
    logic                    upd;
    logic [CNT_W-1:0]        wait_cnt;

    // The instruction being accepted this edge is decoded straight from the input port
    assign cur        = (state == ST_FETCH) ? instr : instr_q;
    assign cur_type   = cur[TYPE_LSB +: 2];
    assign cur_rd     = cur[RD_LSB +: RA_BITS];
    assign cur_rs1    = cur[RS1_LSB +: RA_BITS];
    assign cur_rs2    = cur[RS2_LSB +: RA_BITS];
    assign cur_offset = cur[OFF_LSB +: DATA_WIDTH];
    assign cur_opcode = cur[3:0];

    assign raddr2      = (cur_type == TYPE_STD) ? cur_rs2 : cur_rd;
    assign wr_en       = (state == ST_WRITE_BACK);
    assign instr_ready = (state == ST_FETCH);

    cu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .R0_ZERO    (R0_ZERO)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (cur_rs1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .wr_en  (wr_en),
        .waddr  (cur_rd),
        .wdata  (result2)
    );

    // Edges that enter DECODE, EXECUTE, MEM_ACCESS or a load's WRITE_BACK refresh the datapath controls
    always_comb begin
        upd = 1'b0;
        case (state)
            ST_FETCH:               upd = instr_valid && (cur_type != TYPE_NOP);
            ST_DECODE, ST_EXECUTE:  upd = 1'b1;
            ST_MEM_ACCESS:          upd = mem_ready && (cur_type == TYPE_LOAD);
            default:                upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RESET;
            instr_q  <= '0;
            wait_cnt <= '0;
            operand1 <= '0;
            operand2 <= '0;
            offset   <= '0;
            opcode   <= OPCODE_IDLE;
            sel1     <= 1'b0;
            sel3     <= 1'b0;
            w_r      <= 1'b0;
            retire   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_RESET: state <= ST_FETCH;
                ST_FETCH: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        if (cur_type == TYPE_NOP) begin
                            retire <= 1'b1;
                        end else begin
                            state <= ST_DECODE;
                        end
                    end
                end
                ST_DECODE: state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (cur_type == TYPE_STD) begin
                        state <= ST_WRITE_BACK;
                    end else begin
                        state    <= ST_MEM_ACCESS;
                        wait_cnt <= '0;
                        w_r      <= (cur_type == TYPE_STORE);
                    end
                end
                ST_MEM_ACCESS: begin
                    // A completing access wins over a timeout in the same cycle
                    if (mem_ready) begin
                        w_r <= 1'b0;
                        if (cur_type == TYPE_LOAD) begin
                            state <= ST_WRITE_BACK;
                        end else begin
                            state  <= ST_FETCH;
                            retire <= 1'b1;
                        end
                    end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                        w_r   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WRITE_BACK: begin
                    state  <= ST_FETCH;
                    retire <= 1'b1;
                end
                ST_FAULT: begin
                    fault <= 1'b1;
                    w_r   <= 1'b0;
                end
                default: begin
                    state  <= ST_RESET;
                    w_r    <= 1'b0;
                    sel1   <= 1'b0;
                    sel3   <= 1'b0;
                    opcode <= OPCODE_IDLE;
                end
            endcase

            if (upd) begin
                operand1 <= rdata1;
                operand2 <= rdata2;
                offset   <= cur_offset;
                opcode   <= cur_opcode;
                sel1     <= (cur_type == TYPE_STD);
                sel3     <= (cur_type != TYPE_STD);
            end
        end
    end

endmodule
